// File: rtl/qbert_jump_ctrl.sv
// Q*bert move sequencer: queues joystick jump requests, computes target cube / bad-jump flag,
// handshakes with the sprite layer and tracks position and lives. Optional watchdog: QBERT_JUMP_TIMEOUT_EN.
module qbert_jump_ctrl #(
    parameter int N_ROWS  = 7,
    parameter int N_CUBE  = 28,
    parameter int Q_DEPTH = 4,
`ifdef QBERT_JUMP_TIMEOUT_EN
    parameter int LIVES0  = 3,
    parameter int TIMEOUT = 2**24
`else
    parameter int LIVES0  = 3
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              restart,
    input  logic              req_valid,
    input  logic [2:0]        req_dir,
    output logic              req_ready,
    input  logic              done_move,
    input  logic [2:0]        state_qb,
    output logic [2:0]        e_jump_qb,
    output logic [N_CUBE-1:0] e_next_qb,
    output logic              e_bad_jump,
    output logic [N_CUBE-1:0] position_qb,
    output logic              cube_hit,
    output logic [4:0]        cube_idx,
    output logic [3:0]        lives,
    output logic              busy,
    output logic              timeout_err,
    output logic [2:0]        dbg_state
);

    localparam int RW = $clog2(N_ROWS + 1);
    localparam int PW = $clog2(Q_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [2:0] LAYER_IDLE = 3'b010;
    localparam logic [N_CUBE-1:0] ONE = N_CUBE'(1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_LAND      = 3'd3,
        S_KO        = 3'd4
    } state_t;

    // Handshake: a request is taken on a clock edge where req_valid && req_ready are both high.
    state_t            state_q, state_d;
    logic [2:0]        mem_q [Q_DEPTH];
    logic [2:0]        mem_d [Q_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [RW-1:0]     row_q, row_d, col_q, col_d;
    logic [RW-1:0]     tgt_row_q, tgt_row_d, tgt_col_q, tgt_col_d;
    logic [4:0]        tgt_idx_q, tgt_idx_d;
    logic [2:0]        jump_q, jump_d;
    logic [N_CUBE-1:0] next_q, next_d;
    logic              bad_q, bad_d;
    logic [N_CUBE-1:0] pos_q, pos_d;
    logic              hit_q, hit_d;
    logic [4:0]        idx_q, idx_d;
    logic [3:0]        lives_q, lives_d;
`ifdef QBERT_JUMP_TIMEOUT_EN
    logic [31:0]       tmo_cnt_q, tmo_cnt_d;
    logic              tmo_err_q, tmo_err_d;
`endif

    logic          dir_ok, empty, full, pop_ok, accept, bypass;
    logic          push, pop, flush;
    logic [2:0]    sel_dir;
    logic          t_bad;
    logic [RW-1:0] t_row, t_col;
    logic [4:0]    t_idx;

    assign dir_ok    = (req_dir != 3'd0) && (req_dir <= 3'd4);
    assign empty     = (count_q == '0);
    assign full      = (count_q == CW'(Q_DEPTH));
    assign pop_ok    = (state_q == S_IDLE) && (state_qb == LAYER_IDLE) && !empty;
    assign req_ready = (lives_q != 4'd0) && (!full || pop_ok);
    assign accept    = req_valid && req_ready && dir_ok;
    // An empty queue lets a fresh request go straight to the layer without a FIFO round trip.
    assign bypass    = (state_q == S_IDLE) && (state_qb == LAYER_IDLE) && empty && accept;
    assign sel_dir   = empty ? req_dir : mem_q[rd_ptr_q];

    always_comb begin
        t_bad = 1'b0;
        t_row = row_q;
        t_col = col_q;
        case (sel_dir)
            3'd1: begin
                t_row = row_q + RW'(1);
                t_col = col_q + RW'(1);
                t_bad = (row_q == RW'(N_ROWS - 1));
            end
            3'd2: begin
                t_row = row_q + RW'(1);
                t_bad = (row_q == RW'(N_ROWS - 1));
            end
            3'd3: begin
                t_row = row_q - RW'(1);
                t_bad = (row_q == '0) || (col_q == row_q);
            end
            3'd4: begin
                t_row = row_q - RW'(1);
                t_col = col_q - RW'(1);
                t_bad = (row_q == '0) || (col_q == '0);
            end
            default: t_bad = 1'b1;
        endcase
        t_idx = 5'((int'(t_row) * (int'(t_row) + 1)) / 2 + int'(t_col));
    end

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        tgt_row_d = tgt_row_q;
        tgt_col_d = tgt_col_q;
        tgt_idx_d = tgt_idx_q;
        jump_d    = jump_q;
        next_d    = next_q;
        bad_d     = bad_q;
        pos_d     = pos_q;
        hit_d     = 1'b0;
        idx_d     = idx_q;
        lives_d   = lives_q;
        pop       = 1'b0;
        flush     = 1'b0;
        push      = accept && !bypass;
`ifdef QBERT_JUMP_TIMEOUT_EN
        tmo_cnt_d = '0;
        tmo_err_d = tmo_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if ((state_qb == LAYER_IDLE) && (!empty || accept)) begin
                    pop       = !empty;
                    jump_d    = sel_dir;
                    next_d    = t_bad ? '0 : (ONE << t_idx);
                    bad_d     = t_bad;
                    tgt_row_d = t_row;
                    tgt_col_d = t_col;
                    tgt_idx_d = t_idx;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (!done_move) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (done_move) state_d = S_LAND;
            end
            S_LAND: begin
                jump_d = 3'd0;
                if (!bad_q) begin
                    // A watchdog-forced landing of an off-pyramid jump has no cube to land on.
                    if (next_q != '0) begin
                        pos_d = next_q;
                        row_d = tgt_row_q;
                        col_d = tgt_col_q;
                        hit_d = 1'b1;
                        idx_d = tgt_idx_q;
                    end
                    state_d = S_IDLE;
                end else begin
                    lives_d = (lives_q == 4'd0) ? 4'd0 : lives_q - 4'd1;
                    flush   = 1'b1;
                    state_d = S_KO;
                end
            end
            S_KO: begin
                if (state_qb == LAYER_IDLE) begin
                    row_d   = '0;
                    col_d   = '0;
                    pos_d   = ONE;
                    bad_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
`ifdef QBERT_JUMP_TIMEOUT_EN
        if ((state_q == S_ISSUE) || (state_q == S_WAIT_DONE)) begin
            if (tmo_cnt_q == 32'(TIMEOUT - 1)) begin
                tmo_err_d = 1'b1;
                bad_d     = 1'b0;
                state_d   = S_LAND;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 32'd1;
            end
        end
`endif
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = req_dir;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || restart) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            row_q     <= '0;
            col_q     <= '0;
            tgt_row_q <= '0;
            tgt_col_q <= '0;
            tgt_idx_q <= '0;
            jump_q    <= 3'd0;
            next_q    <= '0;
            bad_q     <= 1'b0;
            pos_q     <= ONE;
            hit_q     <= 1'b0;
            idx_q     <= '0;
            lives_q   <= 4'(LIVES0);
`ifdef QBERT_JUMP_TIMEOUT_EN
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            row_q     <= row_d;
            col_q     <= col_d;
            tgt_row_q <= tgt_row_d;
            tgt_col_q <= tgt_col_d;
            tgt_idx_q <= tgt_idx_d;
            jump_q    <= jump_d;
            next_q    <= next_d;
            bad_q     <= bad_d;
            pos_q     <= pos_d;
            hit_q     <= hit_d;
            idx_q     <= idx_d;
            lives_q   <= lives_d;
`ifdef QBERT_JUMP_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
`endif
        end
    end

    assign e_jump_qb   = jump_q;
    assign e_next_qb   = next_q;
    assign e_bad_jump  = bad_q;
    assign position_qb = pos_q;
    assign cube_hit    = hit_q;
    assign cube_idx    = idx_q;
    assign lives       = lives_q;
    assign busy        = (state_q != S_IDLE);
    assign dbg_state   = state_q;
`ifdef QBERT_JUMP_TIMEOUT_EN
    assign timeout_err = tmo_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_qbert_jump_ctrl.sv
// Bench for qbert_jump_ctrl: directed moves with hand-computed targets, a sprite-layer model,
// and a monitor that pops expected issues/landings from queues.
module tb_qbert_jump_ctrl;

    localparam logic [2:0] L_IDLE = 3'b010, L_JUMP = 3'b001, L_KO = 3'b011, L_STALL = 3'b100;
    localparam logic [2:0] DR = 3'd1, DL = 3'd2, UR = 3'd3, UL = 3'd4;
    localparam logic [2:0] ST_IDLE = 3'd0, ST_WAIT = 3'd2, ST_KO = 3'd4;

    logic        clk, reset, restart, req_valid, req_ready, done_move;
    logic [2:0]  req_dir, state_qb, e_jump_qb, dbg_state;
    logic [27:0] e_next_qb, position_qb;
    logic        e_bad_jump, cube_hit, busy, timeout_err;
    logic [4:0]  cube_idx;
    logic [3:0]  lives;

    int checks = 0, errors = 0, hit_count = 0;
    logic [31:0] exp_issue_q[$];
    logic [32:0] exp_hit_q[$];
    logic [2:0]  prev_jump = 3'd0;
    logic [2:0]  layer_state = L_IDLE;
    logic        stall = 1'b0, layer_active = 1'b0;
    int          jump_len = 3, ko_len = 5;

    assign state_qb = stall ? L_STALL : layer_state;

    qbert_jump_ctrl dut (
        .clk(clk), .reset(reset), .restart(restart), .req_valid(req_valid), .req_dir(req_dir),
        .req_ready(req_ready), .done_move(done_move), .state_qb(state_qb), .e_jump_qb(e_jump_qb),
        .e_next_qb(e_next_qb), .e_bad_jump(e_bad_jump), .position_qb(position_qb),
        .cube_hit(cube_hit), .cube_idx(cube_idx), .lives(lives), .busy(busy),
        .timeout_err(timeout_err), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: bound expired", name);
    endtask

    // driver tasks (called on a negedge, return on a negedge)
    task automatic send(input logic [2:0] dir);
        int t = 0;
        req_valid = 1'b1;
        req_dir   = dir;
        #1;
        while (!req_ready && t < 500) begin
            @(negedge clk); #1; t++;
        end
        if (t >= 500) fail("send_ready");
        @(negedge clk);
        req_valid = 1'b0;
        req_dir   = 3'd0;
    endtask

    task automatic exp_good(input logic [2:0] dir, input logic [4:0] idx, input logic [27:0] pos);
        exp_issue_q.push_back({dir, pos, 1'b0});
        exp_hit_q.push_back({idx, pos});
    endtask

    task automatic exp_bad(input logic [2:0] dir);
        exp_issue_q.push_back({dir, 28'h0, 1'b1});
    endtask

    task automatic wait_quiet();
        int t = 0, q = 0;
        while (q < 4 && t < 2000) begin
            @(negedge clk);
            if (!busy && !layer_active && !stall) q++; else q = 0;
            t++;
        end
        if (q < 4) fail("wait_quiet");
    endtask

    task automatic wait_state(input logic [2:0] st);
        int t = 0;
        while (dbg_state != st && t < 500) begin
            @(negedge clk); t++;
        end
        if (t >= 500) fail("wait_state");
    endtask

    // sprite layer model
    initial begin
        logic bad;
        int t;
        done_move = 1'b1;
        forever begin
            @(negedge clk);
            if (!reset && e_jump_qb != 3'd0) begin
                bad          = e_bad_jump;
                layer_active = 1'b1;
                done_move    = 1'b0;
                layer_state  = L_JUMP;
                repeat (jump_len) @(negedge clk);
                done_move = 1'b1;
                if (bad) begin
                    layer_state = L_KO;
                    repeat (ko_len) @(negedge clk);
                end
                layer_state = L_IDLE;
                t = 0;
                while (e_jump_qb != 3'd0 && t < 50) begin
                    @(negedge clk); t++;
                end
                if (t >= 50) fail("layer_release");
                layer_active = 1'b0;
            end
        end
    end

    // scoreboard monitor
    initial begin
        logic [31:0] ei;
        logic [32:0] eh;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (e_jump_qb != 3'd0 && prev_jump == 3'd0) begin
                    if (exp_issue_q.size() == 0) begin
                        chk("unexpected_issue", {32'd0, e_jump_qb, e_next_qb, e_bad_jump}, 64'd0);
                    end else begin
                        ei = exp_issue_q.pop_front();
                        chk("issue", {32'd0, e_jump_qb, e_next_qb, e_bad_jump}, {32'd0, ei});
                    end
                end
                if (cube_hit) begin
                    hit_count++;
                    if (exp_hit_q.size() == 0) begin
                        chk("unexpected_hit", {59'd0, cube_idx}, 64'h1_0000_0000);
                    end else begin
                        eh = exp_hit_q.pop_front();
                        chk("hit", {31'd0, cube_idx, position_qb}, {31'd0, eh});
                    end
                end
            end
            prev_jump = e_jump_qb;
        end
    end

    initial begin
        reset = 1'b1; restart = 1'b0; req_valid = 1'b0; req_dir = 3'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_position", position_qb, 28'h1);
        chk("rst_jump", e_jump_qb, 0);
        chk("rst_next", e_next_qb, 0);
        chk("rst_bad", e_bad_jump, 0);
        chk("rst_hit", cube_hit, 0);
        chk("rst_idx", cube_idx, 0);
        chk("rst_lives", lives, 3);
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 1);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_state", dbg_state, ST_IDLE);

        // T1: DR, DL, then UL, UR back to the top
        exp_good(DR, 5'd2, 28'h4);
        exp_good(DL, 5'd4, 28'h10);
        send(DR); send(DL);
        wait_quiet();
        chk("t1_hits", hit_count, 2);
        chk("t1_pos", position_qb, 28'h10);
        chk("t1_idx", cube_idx, 4);
        exp_good(UL, 5'd1, 28'h2);
        exp_good(UR, 5'd0, 28'h1);
        send(UL); send(UR);
        wait_quiet();
        chk("t1_pos_top", position_qb, 28'h1);
        chk("t1_hits4", hit_count, 4);

        // T2: UR from the top is a bad jump
        exp_bad(UR);
        send(UR);
        wait_state(ST_KO);
        chk("t2_lives_ko", lives, 2);
        chk("t2_bad_ko", e_bad_jump, 1);
        wait_quiet();
        chk("t2_pos", position_qb, 28'h1);
        chk("t2_bad_clr", e_bad_jump, 0);

        // illegal directions are dropped
        send(3'b000); send(3'b101); send(3'b111);
        wait_quiet();
        chk("drop_lives", lives, 2);

        // T3: stalled layer, queue fills at four
        exp_good(DR, 5'd2, 28'h4);
        exp_good(DL, 5'd4, 28'h10);
        exp_good(DR, 5'd8, 28'h100);
        exp_good(UL, 5'd4, 28'h10);
        exp_good(DL, 5'd7, 28'h80);
        stall = 1'b1;
        send(DR); send(DL); send(DR); send(UL);
        #1;
        chk("t3_ready_full", req_ready, 0);
        stall = 1'b0;
        send(DL);
        wait_quiet();
        chk("t3_pos", position_qb, 28'h80);
        chk("t3_hits", hit_count, 9);

        // T4: bad jump with three queued behind it
        exp_good(UL, 5'd3, 28'h8);
        send(UL);
        wait_quiet();
        exp_bad(UL);
        stall = 1'b1;
        send(UL); send(DR); send(DR); send(DR);
        stall = 1'b0;
        wait_quiet();
        repeat (20) @(negedge clk);
        chk("t4_lives", lives, 1);
        chk("t4_pos", position_qb, 28'h1);
        chk("t4_hits", hit_count, 10);
        chk("t4_idle", busy, 0);

        // T5: restart mid-jump
        jump_len = 12;
        exp_issue_q.push_back({DR, 28'h4, 1'b0});
        send(DR);
        wait_state(ST_WAIT);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("t5_state", dbg_state, ST_IDLE);
        chk("t5_jump", e_jump_qb, 0);
        chk("t5_lives", lives, 3);
        chk("t5_pos", position_qb, 28'h1);
        wait_quiet();
        jump_len = 3;
        chk("t5_no_hit", hit_count, 10);

        // bottom row, then lose every life
        exp_good(DR, 5'd2, 28'h4);
        exp_good(DR, 5'd5, 28'h20);
        exp_good(DR, 5'd9, 28'h200);
        exp_good(DR, 5'd14, 28'h4000);
        exp_good(DR, 5'd20, 28'h100000);
        exp_good(DR, 5'd27, 28'h8000000);
        for (int i = 0; i < 6; i++) send(DR);
        wait_quiet();
        chk("bot_pos", position_qb, 28'h8000000);
        chk("bot_idx", cube_idx, 27);
        exp_bad(DL);
        send(DL);
        wait_quiet();
        chk("bot_lives", lives, 2);
        chk("bot_pos_top", position_qb, 28'h1);
        exp_bad(UR);
        send(UR);
        wait_quiet();
        exp_bad(UL);
        send(UL);
        wait_quiet();
        chk("dead_lives", lives, 0);
        #1;
        chk("dead_ready", req_ready, 0);
        req_valid = 1'b1; req_dir = DR;
        repeat (10) @(negedge clk);
        req_valid = 1'b0; req_dir = 3'd0;
        wait_quiet();
        chk("dead_idle", busy, 0);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        chk("revive_lives", lives, 3);
        #1;
        chk("revive_ready", req_ready, 1);
        exp_good(DL, 5'd1, 28'h2);
        send(DL);
        wait_quiet();
        chk("revive_pos", position_qb, 28'h2);

        chk("issue_q_empty", exp_issue_q.size(), 0);
        chk("hit_q_empty", exp_hit_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
